// File: rtl/neat_gene_pkg.sv
// Shared gene-stream constants, types and helpers for the NEAT genome pipeline.
package neat_gene_pkg;
   localparam int GENE_SZ = 64;
   localparam int ATTR_SZ = 8;
   localparam int LANES   = 3;

   typedef logic [GENE_SZ-1:0] gene_t;
   typedef logic [ATTR_SZ-1:0] attr_t;

   // Field layout of a gene, MSB first: genome_id [63:56], type [55:48], src [47:40], dest [39:32]
   typedef struct packed {
      logic [7:0]  genome_id;
      logic [7:0]  gtype;
      logic [7:0]  src;
      logic [7:0]  dest;
      logic [31:0] payload;
   } gene_fields_t;

   function automatic logic [1:0] popcount3(input logic [LANES-1:0] v);
      return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
   endfunction
endpackage

// File: rtl/gene_stream_collector_if.sv
// Lane-input / single-gene-output bundle between the mutation stage and the genome writer.
interface gene_stream_collector_if;
   import neat_gene_pkg::*;

   gene_t              gene_in1;
   gene_t              gene_in2;
   gene_t              gene_in3;
   logic [LANES-1:0]   in_valid;
   attr_t              hidden_node_max_in;
   logic               in_ready;
   gene_t              gene_out;
   logic               out_valid;
   logic               out_ready;
   attr_t              gene_count;
   attr_t              hidden_node_max_out;
   logic               drop_err;

   modport master (
      output gene_in1, gene_in2, gene_in3, in_valid, hidden_node_max_in, out_ready,
      input  in_ready, gene_out, out_valid, gene_count, hidden_node_max_out, drop_err
   );

   modport slave (
      input  gene_in1, gene_in2, gene_in3, in_valid, hidden_node_max_in, out_ready,
      output in_ready, gene_out, out_valid, gene_count, hidden_node_max_out, drop_err
   );
endinterface

// File: rtl/gene_fifo_3w1r.sv
// Circular gene buffer with three compacted write lanes and one read port.
module gene_fifo_3w1r
   import neat_gene_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         clr_i,
   input  logic                         push_i,
   input  logic [LANES-1:0]             valid_i,
   input  gene_t [LANES-1:0]            wr_data_i,
   input  logic                         pop_i,
   output gene_t                        rd_data_o,
   output logic [$clog2(DEPTH):0]       occ_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int OW = PW + 1;

   gene_t          mem_q [DEPTH];
   logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [OW-1:0]  occ_q, occ_d;
   logic [PW-1:0]  lane_off_s [LANES];
   logic [1:0]     push_cnt_s;

   // Each valid lane lands after the valid lanes older than it, so holes in the mask vanish
   always_comb begin
      push_cnt_s    = push_i ? popcount3(valid_i) : 2'd0;
      lane_off_s[0] = {PW{1'b0}};
      lane_off_s[1] = PW'(valid_i[0]);
      lane_off_s[2] = PW'(valid_i[0]) + PW'(valid_i[1]);
      wr_ptr_d      = wr_ptr_q + PW'(push_cnt_s);
      rd_ptr_d      = rd_ptr_q + PW'(pop_i);
      occ_d         = occ_q + OW'(push_cnt_s) - OW'(pop_i);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         wr_ptr_q <= {PW{1'b0}};
         rd_ptr_q <= {PW{1'b0}};
         occ_q    <= {OW{1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   always_ff @(posedge clk_i) begin
      for (int l = 0; l < LANES; l++) begin
         if (push_i && valid_i[l]) begin
            mem_q[wr_ptr_q + lane_off_s[l]] <= wr_data_i[l];
         end
      end
   end

   assign rd_data_o = mem_q[rd_ptr_q];
   assign occ_o     = occ_q;
endmodule

// File: rtl/gene_stream_collector.sv
// Compacts up to three lane genes per cycle into an in-order single-gene valid/ready stream
// and keeps the per-genome emitted-gene count, hidden-node maximum and sticky drop flag.
module gene_stream_collector
   import neat_gene_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   setup,
   gene_stream_collector_if.slave bus
);
   localparam int OW = $clog2(DEPTH) + 1;

   logic [OW-1:0] occ_s;
   gene_t         rd_data_s;
   logic          clr_s, any_valid_s, out_valid_s, in_ready_s, push_s, pop_s;
   attr_t         gene_count_q, gene_count_d;
   attr_t         hnm_q, hnm_d;
   logic          drop_err_q, drop_err_d;

   // Ready needs room for a full three-lane burst and depends on registered occupancy only
   assign clr_s       = rst | setup;
   assign any_valid_s = (bus.in_valid != {LANES{1'b0}});
   assign out_valid_s = (occ_s != {OW{1'b0}});
   assign in_ready_s  = (occ_s <= OW'(DEPTH - 3));
   assign push_s      = any_valid_s & in_ready_s & ~clr_s;
   assign pop_s       = out_valid_s & bus.out_ready & ~clr_s;

   gene_fifo_3w1r #(.DEPTH(DEPTH)) u_fifo (
      .clk_i     (clk),
      .rst_i     (rst),
      .clr_i     (setup),
      .push_i    (push_s),
      .valid_i   (bus.in_valid),
      .wr_data_i ({bus.gene_in3, bus.gene_in2, bus.gene_in1}),
      .pop_i     (pop_s),
      .rd_data_o (rd_data_s),
      .occ_o     (occ_s)
   );

   always_comb begin
      gene_count_d = gene_count_q;
      hnm_d        = hnm_q;
      drop_err_d   = drop_err_q;
      if (pop_s) gene_count_d = gene_count_q + ATTR_SZ'(1'b1);
      else       gene_count_d = gene_count_q;
      if (push_s && (bus.hidden_node_max_in > hnm_q)) hnm_d = bus.hidden_node_max_in;
      else                                            hnm_d = hnm_q;
      if (any_valid_s && !in_ready_s) drop_err_d = 1'b1;
      else                            drop_err_d = drop_err_q;
   end

   always_ff @(posedge clk) begin
      if (clr_s) begin
         gene_count_q <= {ATTR_SZ{1'b0}};
         hnm_q        <= {ATTR_SZ{1'b0}};
         drop_err_q   <= 1'b0;
      end else begin
         gene_count_q <= gene_count_d;
         hnm_q        <= hnm_d;
         drop_err_q   <= drop_err_d;
      end
   end

   // Empty buffer shows zero rather than a stale entry
   assign bus.gene_out            = out_valid_s ? rd_data_s : {GENE_SZ{1'b0}};
   assign bus.out_valid           = out_valid_s;
   assign bus.in_ready            = in_ready_s;
   assign bus.gene_count          = gene_count_q;
   assign bus.hidden_node_max_out = hnm_q;
   assign bus.drop_err            = drop_err_q;
endmodule

// File: tb/tb_gene_stream_collector.sv
// Directed plus short random stimulus with a gene scoreboard and a reference model of
// occupancy, count, hidden-node maximum and drop flag.
module tb_gene_stream_collector;
   import neat_gene_pkg::*;

   localparam int DEPTH = 8;

   logic clk = 1'b0;
   logic rst;
   logic setup;

   gene_stream_collector_if bus ();

   gene_stream_collector #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .setup (setup),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int            errors = 0;
   int            checks = 0;
   gene_t         sb [$];
   int            m_occ  = 0;
   attr_t         m_cnt  = 8'd0;
   attr_t         m_hnm  = 8'd0;
   logic          m_drop = 1'b0;
   int            gid    = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic gene_t mk_gene(input int n);
      gene_fields_t f;
      f.genome_id = 8'h5A;
      f.gtype     = 8'(n % 3);
      f.src       = 8'(n);
      f.dest      = 8'(n + 1);
      f.payload   = 32'hC0DE_0000 + 32'(n);
      return gene_t'(f);
   endfunction

   task automatic drive(input logic [2:0] iv, input attr_t hin);
      bus.in_valid           = iv;
      bus.gene_in1           = mk_gene(gid);
      bus.gene_in2           = mk_gene(gid + 1);
      bus.gene_in3           = mk_gene(gid + 2);
      bus.hidden_node_max_in = hin;
      gid += 3;
   endtask

   task automatic idle();
      bus.in_valid = 3'b000;
   endtask

   // Compare current outputs with the model, advance the model, then step one clock
   task automatic tick();
      logic [2:0] iv;
      logic       pop;
      int         n;
      iv = bus.in_valid;
      chk("out_valid", bus.out_valid, (m_occ != 0));
      chk("in_ready", bus.in_ready, (m_occ <= DEPTH - 3));
      chk("gene_count", bus.gene_count, m_cnt);
      chk("hnm_out", bus.hidden_node_max_out, m_hnm);
      chk("drop_err", bus.drop_err, m_drop);
      if (rst || setup) begin
         sb.delete();
         m_occ  = 0;
         m_cnt  = 8'd0;
         m_hnm  = 8'd0;
         m_drop = 1'b0;
      end else begin
         pop = (m_occ != 0) && bus.out_ready;
         if (pop) begin
            chk("gene_out", bus.gene_out, sb[0]);
            void'(sb.pop_front());
            m_cnt = m_cnt + 8'd1;
         end
         if (iv != 3'b000) begin
            if (m_occ <= DEPTH - 3) begin
               n = 0;
               if (iv[0]) begin sb.push_back(bus.gene_in1); n++; end
               if (iv[1]) begin sb.push_back(bus.gene_in2); n++; end
               if (iv[2]) begin sb.push_back(bus.gene_in3); n++; end
               m_occ += n;
               if (bus.hidden_node_max_in > m_hnm) m_hnm = bus.hidden_node_max_in;
            end else begin
               m_drop = 1'b1;
            end
         end
         if (pop) m_occ -= 1;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst                    = 1'b1;
      setup                  = 1'b0;
      bus.in_valid           = 3'b000;
      bus.gene_in1           = 64'd0;
      bus.gene_in2           = 64'd0;
      bus.gene_in3           = 64'd0;
      bus.hidden_node_max_in = 8'd0;
      bus.out_ready          = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset_gene_out", bus.gene_out, 64'd0);
      chk("reset_in_ready", bus.in_ready, 64'd1);

      // 1: single gene, one-cycle latency
      bus.out_ready = 1'b1;
      drive(3'b001, 8'd0);
      chk("t1_not_yet_valid", bus.out_valid, 64'd0);
      tick();
      idle();
      chk("t1_gene_out", bus.gene_out, mk_gene(0));
      tick();
      tick();
      chk("t1_count", bus.gene_count, 64'd1);

      // 2: compaction of 111 then 101
      drive(3'b111, 8'd0);
      tick();
      drive(3'b101, 8'd0);
      tick();
      idle();
      repeat (7) tick();
      chk("t2_count", bus.gene_count, 64'd6);

      // 3: overflow with setup racing a push
      setup = 1'b1;
      drive(3'b001, 8'd0);
      tick();
      setup = 1'b0;
      idle();
      tick();
      bus.out_ready = 1'b0;
      repeat (6) begin
         drive(3'b001, 8'd1);
         tick();
      end
      chk("t3_in_ready_low", bus.in_ready, 64'd0);
      drive(3'b001, 8'd1);
      tick();
      idle();
      chk("t3_drop_err", bus.drop_err, 64'd1);
      bus.out_ready = 1'b1;
      repeat (8) tick();
      chk("t3_count", bus.gene_count, 64'd6);

      // 4: push 011 while popping at occupancy 5
      setup = 1'b1;
      tick();
      setup = 1'b0;
      bus.out_ready = 1'b0;
      drive(3'b111, 8'd0);
      tick();
      drive(3'b011, 8'd0);
      tick();
      chk("t4_ready_at5", bus.in_ready, 64'd1);
      bus.out_ready = 1'b1;
      drive(3'b011, 8'd0);
      tick();
      idle();
      chk("t4_ready_at6", bus.in_ready, 64'd0);
      repeat (8) tick();

      // 5: hidden node maximum
      setup = 1'b1;
      tick();
      setup = 1'b0;
      drive(3'b001, 8'd4);
      tick();
      drive(3'b001, 8'd9);
      tick();
      drive(3'b001, 8'd7);
      tick();
      idle();
      chk("t5_hnm", bus.hidden_node_max_out, 64'd9);
      setup = 1'b1;
      tick();
      setup = 1'b0;
      chk("t5_hnm_cleared", bus.hidden_node_max_out, 64'd0);

      // 6: reset mid-stream
      bus.out_ready = 1'b0;
      drive(3'b111, 8'd3);
      tick();
      drive(3'b001, 8'd3);
      tick();
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t6_out_valid", bus.out_valid, 64'd0);
      chk("t6_count", bus.gene_count, 64'd0);
      chk("t6_in_ready", bus.in_ready, 64'd1);
      bus.out_ready = 1'b1;
      drive(3'b001, 8'd2);
      tick();
      idle();
      chk("t6_new_gene", bus.gene_out, mk_gene(gid - 3));
      repeat (2) tick();

      // random mix to exercise pointer wrap and backpressure
      for (int i = 0; i < 60; i++) begin
         drive(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
         bus.out_ready = 1'($urandom_range(0, 1));
         tick();
      end
      idle();
      bus.out_ready = 1'b1;
      repeat (10) tick();
      chk("final_empty", bus.out_valid, 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
